// File: rtl/fetch_pc_unit_pkg.sv
// Shared ISA definitions for the fetch side: opcodes, PC source select, instruction fields
// and the two PC target helpers used by the fetch stage.
package fetch_pc_unit_pkg;

  // LB covers both LBu and LBs; the sign choice lives in the function bits.
  typedef enum logic [3:0] {
    OP_AND  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_ADDI = 4'h3,
    OP_ANDI = 4'h4,
    OP_LW   = 4'h5,
    OP_LB   = 4'h6,
    OP_SW   = 4'h7,
    OP_BGT  = 4'h8,
    OP_BLT  = 4'h9,
    OP_BEQ  = 4'hA,
    OP_BNE  = 4'hB,
    OP_JMP  = 4'hC,
    OP_CALL = 4'hD,
    OP_RET  = 4'hE,
    OP_SV   = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10,
    PC_RET = 2'b11
  } pc_src_e;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int JIMM_MSB = 11;
  localparam int JIMM_LSB = 0;
  localparam int IIMM_MSB = 4;
  localparam int IIMM_LSB = 0;
  localparam int IIMM_W   = IIMM_MSB - IIMM_LSB + 1;

  // Branch displacement in bytes: sign-extended I-immediate times two.
  function automatic logic [15:0] br_offset(input logic [15:0] ir);
    return {{(15 - IIMM_W){ir[IIMM_MSB]}}, ir[IIMM_MSB:IIMM_LSB], 1'b0};
  endfunction

  // J-type target keeps the current 8 KiB region of the PC.
  function automatic logic [15:0] jmp_target(input logic [15:0] pc, input logic [15:0] ir);
    return {pc[15:13], ir[JIMM_MSB:JIMM_LSB], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Control/memory side bundle of the fetch PC unit: strobes, PC source select, IR and status.
// master = control FSM / instruction memory side, slave = fetch_pc_unit.
interface fetch_pc_unit_if;
  logic [15:0] pc_out;
  logic [15:0] instr_in;
  logic        ir_write;
  logic [15:0] ir_out;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        branch_taken;
  logic        is_call;
  logic        ras_ovf;
  logic        ras_unf;
  logic        fetch_fault;

  modport master (
    output instr_in, ir_write, pc_write, pc_src, branch_taken, is_call,
    input  pc_out, ir_out, ras_ovf, ras_unf, fetch_fault
  );

  modport slave (
    input  instr_in, ir_write, pc_write, pc_src, branch_taken, is_call,
    output pc_out, ir_out, ras_ovf, ras_unf, fetch_fault
  );
endinterface

// File: rtl/fetch_pc_unit_ret_addr_stack.sv
// Return-address stack: LIFO of DEPTH entries, top readable combinationally, one-cycle update.
// Overflowing pushes are dropped and underflowing pops are ignored; both raise sticky flags.
module ret_addr_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] push_dat_i,
  output logic [W-1:0] top_o,
  output logic         empty_o,
  output logic         ovf_o,
  output logic         unf_o
);
  localparam int IDXW = $clog2(DEPTH);
  localparam int SPW  = $clog2(DEPTH + 1);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  logic [W-1:0]    mem_q [DEPTH];
  logic [SPW-1:0]  sp_q, sp_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            full;
  logic            wr_en;
  logic [IDXW-1:0] wr_idx;
  logic [IDXW-1:0] rd_idx;

  assign full    = (sp_q == SP_FULL);
  assign empty_o = (sp_q == '0);
  assign wr_idx  = sp_q[IDXW-1:0];
  assign rd_idx  = IDXW'(sp_q - SPW'(1));
  assign top_o   = mem_q[rd_idx];
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

  always_comb begin
    sp_d  = sp_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    wr_en = 1'b0;
    if (push_i) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        wr_en = 1'b1;
        sp_d  = sp_q + SPW'(1);
      end
    end else if (pop_i) begin
      if (empty_o) begin
        unf_d = 1'b1;
      end else begin
        sp_d = sp_q - SPW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sp_q  <= sp_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      if (wr_en) begin
        mem_q[wr_idx] <= push_dat_i;
      end
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: PC register, IR latch and next-PC select (seq/branch/jump/call/ret); updates one edge after a strobe, holds otherwise.
// Optional target bounds check against IMEM_BYTES is enabled by defining FETCH_BOUNDS_CHECK_EN.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int RAS_DEPTH  = 4,
  parameter int IMEM_BYTES = 32
) (
  input logic            clk,
  input logic            reset,
  fetch_pc_unit_if.slave bus
);
`ifdef FETCH_BOUNDS_CHECK_EN
  localparam bit BOUNDS_CHK = 1'b1;
`else
  localparam bit BOUNDS_CHK = 1'b0;
`endif
  localparam logic [16:0] PC_LIMIT = 17'(IMEM_BYTES - 2);

  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        fault_q, fault_d;
  logic [15:0] seq_pc;
  logic [15:0] tgt_pc;
  logic        tgt_fault;
  logic [15:0] ras_top;
  logic        ras_empty;
  logic        ras_push;
  logic        ras_pop;
  logic        ras_ovf;
  logic        ras_unf;

  assign seq_pc = pc_q + 16'd2;

  // A RET on an empty stack falls through to the next sequential instruction.
  always_comb begin
    tgt_pc = seq_pc;
    case (bus.pc_src)
      PC_SEQ: tgt_pc = seq_pc;
      PC_BR:  tgt_pc = bus.branch_taken ? (pc_q + br_offset(ir_q)) : seq_pc;
      PC_JMP: tgt_pc = jmp_target(pc_q, ir_q);
      PC_RET: tgt_pc = ras_empty ? seq_pc : ras_top;
    endcase
  end

  assign tgt_fault = BOUNDS_CHK && ({1'b0, tgt_pc} > PC_LIMIT);

  // A faulting RET still consumes its entry; a faulting CALL pushes nothing.
  assign ras_pop  = bus.pc_write && (bus.pc_src == PC_RET);
  assign ras_push = bus.pc_write && (bus.pc_src == PC_JMP) && bus.is_call && !tgt_fault;

  always_comb begin
    pc_d    = (bus.pc_write && !tgt_fault) ? tgt_pc : pc_q;
    ir_d    = bus.ir_write ? bus.instr_in : ir_q;
    fault_d = fault_q | (bus.pc_write & tgt_fault);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= '0;
      ir_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      fault_q <= fault_d;
    end
  end

  ret_addr_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (16)
  ) u_ras (
    .clk        (clk),
    .reset      (reset),
    .push_i     (ras_push),
    .pop_i      (ras_pop),
    .push_dat_i (seq_pc),
    .top_o      (ras_top),
    .empty_o    (ras_empty),
    .ovf_o      (ras_ovf),
    .unf_o      (ras_unf)
  );

  assign bus.pc_out      = pc_q;
  assign bus.ir_out      = ir_q;
  assign bus.ras_ovf     = ras_ovf;
  assign bus.ras_unf     = ras_unf;
  assign bus.fetch_fault = fault_q;

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-side stage directly upstream of the instruction memory in the multicycle RISC core.
- Holds the architectural PC that drives the instruction-memory address, and latches the 16-bit instruction word into an instruction register (IR).
- Computes the next PC for sequential, branch, JMP, CALL and RET flows.
- Owns a small return-address stack (RAS) for CALL/RET.
- Sequenced by the control FSM through write-enable strobes; holds state between strobes.

Parameters:
- RAS_DEPTH, 4, number of return-address entries (power of 2, 2..16).
- IMEM_BYTES, 32, instruction memory size in bytes; used only by the optional bounds check.

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- pc_out  out  16  current PC, byte address, drives instruction-memory address.
- instr_in  in  16  instruction word returned by instruction memory for pc_out.
- ir_write  in  1  latch instr_in into IR this cycle.
- ir_out  out  16  instruction register contents.
- pc_write  in  1  update PC this cycle according to pc_src.
- pc_src  in  2  00 seq, 01 branch, 10 jump/call, 11 ret.
- branch_taken  in  1  comparison result from ALU; qualifies pc_src=01.
- is_call  in  1  with pc_src=10, push return address.
- ras_ovf  out  1  sticky: push attempted while RAS full.
- ras_unf  out  1  sticky: pop attempted while RAS empty.
- fetch_fault  out  1  sticky; exists only with the optional feature, tied 0 otherwise.

Behaviour:
- Reset (synchronous, highest priority): pc_out=0x0000, ir_out=0x0000, RAS pointer=0, all entries 0, ras_ovf=0, ras_unf=0, fetch_fault=0.
- Reset mid-operation aborts any pending update; no RAS write occurs in the reset cycle.
- IR:
  - ir_write=1: ir_out <= instr_in on the next edge (1-cycle latency).
  - Otherwise IR holds its value.
  - ir_write and pc_write in the same cycle: IR captures the word for the old PC; PC updates. Both take effect.
- PC when pc_write=1 (P = current pc_out; all sums modulo 2^16, wrap silently):
  - pc_src 00: P + 2.
  - pc_src 01: if branch_taken, P + (sext16(ir_out[4:0]) << 1); else P + 2.
  - pc_src 10: {P[15:13], ir_out[11:0], 1'b0} (J-type 12-bit word target).
    - If is_call=1, also push P + 2 onto the RAS.
  - pc_src 11: pop the RAS into PC.
- PC when pc_write=0: PC holds; pc_src, branch_taken and is_call are ignored.
- All PC results are even by construction; bit 0 is always written 0.
- RAS:
  - LIFO with pointer sp in 0..RAS_DEPTH.
  - Push writes entry[sp] and increments sp.
  - Pop reads entry[sp-1] and decrements sp.
  - Push when sp==RAS_DEPTH: entry not written, sp unchanged, ras_ovf set; the PC jump still happens.
  - Pop when sp==0: PC <= P + 2, sp unchanged, ras_unf set.
  - Push and pop can never coincide (pc_src is exclusive).
- Sticky flags clear only on reset.
- pc_out is driven directly from the PC register, so instruction memory sees the new address the cycle after pc_write.

Optional Feature:
- Macro: FETCH_BOUNDS_CHECK_EN.
- Defined:
  - If a computed next PC is greater than IMEM_BYTES-2, the PC is not updated and fetch_fault is set (sticky until reset).
  - A CALL that faults performs no push.
  - A RET that faults still pops.
- Undefined: no check is made, all targets are accepted, and fetch_fault is a constant 0.

Decomposition:
- Shared package pkg_core_isa:
  - opcode constants (AND, ADD, SUB, ADDI, ANDI, LW, LBu/LBs, SW, BGT..BNE, JMP, CALL, RET, Sv).
  - pc_src encodings PC_SEQ, PC_BR, PC_JMP, PC_RET.
  - instruction field positions (opcode [15:12], J-imm [11:0], I-imm [4:0]).
- One natural sub-module, ret_addr_stack: RAS storage, pointer, full/empty, and the ovf/unf flags. The PC mux, adders and IR stay in the parent.

Test Plan:
- Sequential flow: after reset, pulse ir_write and pc_write with pc_src=00 three times -> pc_out 0x0000, 0x0002, 0x0004, 0x0006; ir_out tracks instr_in; reset in the middle -> pc_out=0 and ir_out=0 the next cycle.
- Branch: PC=0x0004, IR=0x8803 (I-imm=3).
  - branch_taken=1 -> pc_out=0x000A.
  - Repeat with IR imm=5'b11111 (-1) -> pc_out=0x0002.
  - branch_taken=0 -> pc_out=0x0006.
- JMP/CALL/RET: PC=0x0014, IR=0xD00D, pc_src=10, is_call=1 -> pc_out=0x001A and RAS top=0x0016; then pc_src=11 -> pc_out=0x0016 and sp=0.
- RAS limits:
  - RAS_DEPTH+1 consecutive CALLs -> the last push is dropped, ras_ovf=1, and RETs return the first RAS_DEPTH addresses in LIFO order.
  - A RET on an empty stack at PC=0x0010 -> pc_out=0x0012, ras_unf=1.
- Wrap: PC=0xFFFE, pc_src=00 -> pc_out=0x0000 with no flag (macro undefined).
- With FETCH_BOUNDS_CHECK_EN and IMEM_BYTES=32: JMP with IR=0xC010 (target 0x0020) -> pc_out unchanged and fetch_fault=1; CALL to the same target -> no push and sp unchanged.
